// File: rtl/rx_baud_timer.sv
// RX bit-timing engine: one mid-bit sample strobe per bit over a whole frame, with a runtime-loadable divisor.
// Optional x16 oversample tick output enabled by defining RX_BAUD_X16_EN.
module rx_baud_timer #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 5208,
    parameter int unsigned FRAME_BITS  = 10,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Div_Load,
    input  logic [DIV_W-1:0] Div_Value,
    output logic             BPS_CLK,
    output logic [IDX_W-1:0] Bit_Idx,
    output logic             Busy,
    output logic             Frame_Done,
`ifdef RX_BAUD_X16_EN
    output logic             Os_Tick,
`endif
    output logic [DIV_W-1:0] Div_Active
);

`ifdef RX_BAUD_X16_EN
    localparam int unsigned DIV_MIN = 32;
`else
    localparam int unsigned DIV_MIN = 4;
`endif

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             frame_done_q, frame_done_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_flag_q, pend_flag_d;

    logic [DIV_W-1:0] div_clamped;
    logic             bit_end;
    logic             last_bit;
    logic             busy_fall;

    // Clamp keeps the half-bit strobe clear of both counter ends
    assign div_clamped = (Div_Value < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : Div_Value;
    assign bit_end     = (cnt_q == div_active_q - DIV_W'(1));
    assign last_bit    = (bit_idx_q == IDX_W'(FRAME_BITS - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        frame_done_d = 1'b0;
        div_active_d = div_active_q;
        div_pend_d   = div_pend_q;
        pend_flag_d  = pend_flag_q;
        busy_fall    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Div_Load) begin
                    div_active_d = div_clamped;
                end
                if (Start && !Abort) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            ST_RUN: begin
                if (Div_Load) begin
                    div_pend_d  = div_clamped;
                    pend_flag_d = 1'b1;
                end
                if (Abort) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    busy_fall = 1'b1;
                end else if (bit_end) begin
                    cnt_d = '0;
                    if (last_bit) begin
                        state_d      = ST_IDLE;
                        bit_idx_d    = '0;
                        frame_done_d = 1'b1;
                        busy_fall    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                // Deferred divisor takes effect only once the frame is over; a same-cycle load is the newest
                if (busy_fall) begin
                    if (Div_Load) begin
                        div_active_d = div_clamped;
                    end else if (pend_flag_q) begin
                        div_active_d = div_pend_q;
                    end
                    pend_flag_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
            div_active_q <= DIV_W'(DEFAULT_DIV);
            div_pend_q   <= '0;
            pend_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            frame_done_q <= frame_done_d;
            div_active_q <= div_active_d;
            div_pend_q   <= div_pend_d;
            pend_flag_q  <= pend_flag_d;
        end
    end

    assign Busy       = (state_q == ST_RUN);
    assign BPS_CLK    = Busy && (cnt_q == (div_active_q >> 1));
    assign Bit_Idx    = bit_idx_q;
    assign Frame_Done = frame_done_q;
    assign Div_Active = div_active_q;

`ifdef RX_BAUD_X16_EN
    logic [DIV_W-1:0] os_cnt_q, os_cnt_d;
    logic [4:0]       os_num_q, os_num_d;
    logic [DIV_W-1:0] os_period;
    logic             os_wrap;

    assign os_period = div_active_q >> 4;
    assign os_wrap   = (os_cnt_q == os_period - DIV_W'(1));

    // Oversample phase restarts at every bit boundary; ticks beyond 16 per bit are suppressed
    always_comb begin
        os_cnt_d = os_cnt_q;
        os_num_d = os_num_q;
        if (!Busy || bit_end || (state_d != ST_RUN)) begin
            os_cnt_d = '0;
            os_num_d = '0;
        end else if (os_wrap) begin
            os_cnt_d = '0;
            if (os_num_q < 5'd16) begin
                os_num_d = os_num_q + 5'd1;
            end
        end else begin
            os_cnt_d = os_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            os_cnt_q <= '0;
            os_num_q <= '0;
        end else begin
            os_cnt_q <= os_cnt_d;
            os_num_q <= os_num_d;
        end
    end

    assign Os_Tick = Busy && os_wrap && (os_num_q < 5'd16);
`endif

endmodule
